dsp_failover_ctrl: RTL and testbench
====================================

DSP_FAILOVER_CTRL -- requirements
Module: dsp_failover_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 30; cycles a fault input must stay high before it is acted on.
REQ-002 SHALL have parameter GUARD, default 300; dead cycles with neither DSP enabled during a handover.
REQ-003 SHALL have parameter RST_PULSE, default 3000; low time of oRstA_n, 100 us at 30 MHz.
REQ-004 SHALL have parameter RECOVER, default 45000; wait after the DSP A reset before A's health is judged.
REQ-005 SHALL have port iClk, input, 1 bit; the 30 MHz system clock.
REQ-006 SHALL have port iRst, input, 1 bit; synchronous active-high reset.
REQ-007 SHALL have port iFaultA, input, 1 bit; DSP A watchdog output, high means fault, synchronous to iClk.
REQ-008 SHALL have port iFaultB, input, 1 bit; DSP B watchdog output, high means fault, synchronous to iClk.
REQ-009 SHALL have port oEnA, output, 1 bit; DSP A owns the shared bus.
REQ-010 SHALL have port oEnB, output, 1 bit; DSP B owns the shared bus.
REQ-011 SHALL have port oRstA_n, output, 1 bit; active-low reset to DSP A.
REQ-012 SHALL have port oWdRearmA, output, 1 bit; one-cycle re-arm pulse to DSP A's watchdog.
REQ-013 SHALL have port oFailAll, output, 1 bit; both DSPs are faulted.
REQ-014 SHALL have port oSwitchCnt, output, 8 bits; count of completed handovers.
REQ-015 SHALL have port oState, output, 3 bits; current FSM state encoding.

Function
REQ-016 SHALL debounce each fault input: a counter increments while the input is high, saturates at DEBOUNCE and clears to 0 in the cycle the input is low; the debounced fault is counter==DEBOUNCE.
REQ-017 SHALL implement states RUN_A=0, GUARD_AB=1, RST_A=2, WAIT_A=3, RUN_B=4, GUARD_BA=5, FAIL_ALL=6.
REQ-018 SHALL, in RUN_A, drive oEnA=1 and move to GUARD_AB on debounced fault A.
REQ-019 SHALL, in GUARD_AB and GUARD_BA, drive oEnA=oEnB=0 for exactly GUARD cycles; GUARD_AB then goes to RST_A and GUARD_BA goes to RUN_A.
REQ-020 SHALL, in RST_A, drive oEnB=1 and oRstA_n=0 for RST_PULSE cycles, then go to WAIT_A.
REQ-021 SHALL pulse oWdRearmA for one cycle on the RST_A to WAIT_A transition, and clear the A debounce counter in that same cycle.
REQ-022 SHALL, in WAIT_A, drive oEnB=1 for RECOVER cycles, then go to GUARD_BA if debounced fault A is clear and FAILBACK_EN is defined, else to RUN_B.
REQ-023 SHALL, in RUN_B, drive oEnB=1, and on debounced fault B go to GUARD_BA if debounced fault A is clear, else to FAIL_ALL.
REQ-024 SHALL, on debounced fault B in RST_A or WAIT_A, go to FAIL_ALL; fault B takes priority over timer expiry in the same cycle.
REQ-025 SHALL, in FAIL_ALL, drive oEnA=oEnB=0, oRstA_n=1 and oFailAll=1, and leave FAIL_ALL only on iRst.
REQ-026 SHALL never assert oEnA and oEnB in the same cycle.
REQ-027 SHALL register all outputs, with a one-cycle latency from the state register.
REQ-028 SHALL increment oSwitchCnt on each entry to RST_A or RUN_A from a guard state, saturating at 255 with no wrap.
REQ-029 SHALL use 16-bit phase timers that reload to 0 on every state entry.

Reset
REQ-030 SHALL, on iRst, set state RUN_A, oEnA=1, oEnB=0, oRstA_n=1, oWdRearmA=0, oFailAll=0, oSwitchCnt=0, all counters 0.
REQ-031 SHALL let iRst in any state, including mid-RST_A, override all transitions in that cycle.

Configuration
REQ-032 SHALL compile the automatic failback to DSP A only when FAILOVER_FAILBACK_EN is defined.
REQ-033 SHALL, without FAILOVER_FAILBACK_EN, never leave WAIT_A for GUARD_BA; control returns to A only via fault B in RUN_B or via iRst.

Structure
REQ-034 SHALL place the state enum, STATE_W=3 and TIMER_W=16 in package dsp_failover_pkg.
REQ-035 SHALL implement the debouncer as sub-module fault_debounce, instantiated twice.

Verification
REQ-036 SHALL check: iFaultA high for 29 cycles, then low -> stays RUN_A, oEnA=1, oSwitchCnt=0.
REQ-037 SHALL check: iFaultA held high -> GUARD_AB 31 cycles later; 300 cycles with both enables 0; oRstA_n low for 3000 cycles; oWdRearmA pulse; oSwitchCnt=1.
REQ-038 SHALL check, with FAILBACK_EN and A healthy after 45000 cycles -> GUARD_BA, then RUN_A with oEnA=1 and oSwitchCnt=2; without FAILBACK_EN -> RUN_B.
REQ-039 SHALL check: iFaultB raised during WAIT_A -> FAIL_ALL, oFailAll=1, both enables 0, state held until iRst.
REQ-040 SHALL check: iRst asserted mid-RST_A -> next cycle RUN_A, oRstA_n=1, oEnA=1, oSwitchCnt=0.
REQ-041 SHALL check: forcing 300 failovers -> oSwitchCnt saturates at 255, and oEnA & oEnB is never 1 in any cycle.

Source files
------------

// File: rtl/dsp_failover_pkg.sv
// Shared types and widths for the dual-DSP failover controller.
package dsp_failover_pkg;

    localparam int STATE_W = 3;
    localparam int TIMER_W = 16;

    typedef enum logic [STATE_W-1:0] {
        RUN_A    = 3'd0,
        GUARD_AB = 3'd1,
        RST_A    = 3'd2,
        WAIT_A   = 3'd3,
        RUN_B    = 3'd4,
        GUARD_BA = 3'd5,
        FAIL_ALL = 3'd6
    } state_e;

    function automatic logic is_guard(input state_e s);
        return (s == GUARD_AB) || (s == GUARD_BA);
    endfunction

endpackage

// File: rtl/dsp_failover_ctrl_fault_debounce.sv
// Saturating high-time counter for one watchdog fault line; the fault is
// reported only once the line has been high for DEBOUNCE consecutive cycles.
module fault_debounce
    import dsp_failover_pkg::*;
#(
    parameter int DEBOUNCE = 30
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic fault_i,
    input  logic clr_i,
    output logic fault_o
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(DEBOUNCE);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    // clr_i wins over a still-high input so a freshly reset DSP starts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !fault_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fault_o = (cnt_q == LIMIT);

endmodule

// File: rtl/dsp_failover_ctrl.sv
// Dual-DSP failover controller: moves the shared bus from DSP A to DSP B on a debounced
// A fault, resets and re-arms A. Automatic failback to A is built only with FAILOVER_FAILBACK_EN.
module dsp_failover_ctrl
    import dsp_failover_pkg::*;
#(
    parameter int DEBOUNCE  = 30,
    parameter int GUARD     = 300,
    parameter int RST_PULSE = 3000,
    parameter int RECOVER   = 45000
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iFaultA,
    input  logic               iFaultB,
    output logic               oEnA,
    output logic               oEnB,
    output logic               oRstA_n,
    output logic               oWdRearmA,
    output logic               oFailAll,
    output logic [7:0]         oSwitchCnt,
    output logic [STATE_W-1:0] oState
);

    localparam logic [TIMER_W-1:0] GUARD_LAST   = TIMER_W'(GUARD - 1);
    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_PULSE - 1);
    localparam logic [TIMER_W-1:0] RECOVER_LAST = TIMER_W'(RECOVER - 1);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [7:0]         sw_cnt_q, sw_cnt_d;
    logic               rearm_d, rearm_q;
    logic               sw_entry;

    logic [1:0]         fault_raw, fault_clr, fault_deb;
    logic               fault_a, fault_b;

    logic               en_a_d, en_b_d, rst_a_n_d, fail_all_d;
    logic               en_a_q, en_b_q, rst_a_n_q, fail_all_q, wd_rearm_q;
    logic [7:0]         sw_out_q;
    state_e             state_out_q;

    assign fault_raw = {iFaultB, iFaultA};
    assign fault_clr = {1'b0, rearm_d};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            fault_debounce #(
                .DEBOUNCE(DEBOUNCE)
            ) u_deb (
                .clk_i  (iClk),
                .rst_i  (iRst),
                .fault_i(fault_raw[gi]),
                .clr_i  (fault_clr[gi]),
                .fault_o(fault_deb[gi])
            );
        end
    endgenerate

    assign fault_a = fault_deb[0];
    assign fault_b = fault_deb[1];

    // Next-state logic; a B fault is checked before any timer expiry
    always_comb begin
        state_d = state_q;
        rearm_d = 1'b0;
        case (state_q)
            RUN_A: begin
                if (fault_a) state_d = GUARD_AB;
            end
            GUARD_AB: begin
                if (timer_q == GUARD_LAST) state_d = RST_A;
            end
            RST_A: begin
                if (fault_b) begin
                    state_d = FAIL_ALL;
                end else if (timer_q == RST_LAST) begin
                    state_d = WAIT_A;
                    rearm_d = 1'b1;
                end
            end
            WAIT_A: begin
                if (fault_b) begin
                    state_d = FAIL_ALL;
                end else if (timer_q == RECOVER_LAST) begin
`ifdef FAILOVER_FAILBACK_EN
                    state_d = fault_a ? RUN_B : GUARD_BA;
`else
                    state_d = RUN_B;
`endif
                end
            end
            RUN_B: begin
                if (fault_b) state_d = fault_a ? FAIL_ALL : GUARD_BA;
            end
            GUARD_BA: begin
                if (timer_q == GUARD_LAST) state_d = RUN_A;
            end
            FAIL_ALL: begin
                state_d = FAIL_ALL;
            end
            default: begin
                state_d = FAIL_ALL;
            end
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != {TIMER_W{1'b1}}) begin
            timer_d = timer_q + 1'b1;
        end
    end

    assign sw_entry = is_guard(state_q) && (state_d != state_q) &&
                      ((state_d == RST_A) || (state_d == RUN_A));

    always_comb begin
        sw_cnt_d = sw_cnt_q;
        if (sw_entry && (sw_cnt_q != 8'hFF)) begin
            sw_cnt_d = sw_cnt_q + 8'd1;
        end
    end

    // Per-state output decode; enables are mutually exclusive by construction
    always_comb begin
        en_a_d     = 1'b0;
        en_b_d     = 1'b0;
        rst_a_n_d  = 1'b1;
        fail_all_d = 1'b0;
        case (state_q)
            RUN_A:         en_a_d     = 1'b1;
            RST_A: begin
                en_b_d    = 1'b1;
                rst_a_n_d = 1'b0;
            end
            WAIT_A, RUN_B: en_b_d     = 1'b1;
            FAIL_ALL:      fail_all_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= RUN_A;
            timer_q  <= '0;
            sw_cnt_q <= '0;
            rearm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            sw_cnt_q <= sw_cnt_d;
            rearm_q  <= rearm_d;
        end
    end

    // Output stage lags the state register by one cycle; the re-arm pulse is
    // delayed once more so it lines up with oState first showing WAIT_A
    always_ff @(posedge iClk) begin
        if (iRst) begin
            en_a_q      <= 1'b1;
            en_b_q      <= 1'b0;
            rst_a_n_q   <= 1'b1;
            fail_all_q  <= 1'b0;
            wd_rearm_q  <= 1'b0;
            sw_out_q    <= '0;
            state_out_q <= RUN_A;
        end else begin
            en_a_q      <= en_a_d;
            en_b_q      <= en_b_d;
            rst_a_n_q   <= rst_a_n_d;
            fail_all_q  <= fail_all_d;
            wd_rearm_q  <= rearm_q;
            sw_out_q    <= sw_cnt_q;
            state_out_q <= state_q;
        end
    end

    assign oEnA       = en_a_q;
    assign oEnB       = en_b_q;
    assign oRstA_n    = rst_a_n_q;
    assign oWdRearmA  = wd_rearm_q;
    assign oFailAll   = fail_all_q;
    assign oSwitchCnt = sw_out_q;
    assign oState     = state_out_q;

endmodule

// File: tb/tb_dsp_failover_ctrl.sv
// Scoreboard bench for dsp_failover_ctrl with shortened phase lengths; expected
// state transitions (with arrival cycle and outputs) are queued as stimulus is driven.
module tb_dsp_failover_ctrl;
    import dsp_failover_pkg::*;

    localparam int DB = 6;
    localparam int GD = 12;
    localparam int RP = 30;
    localparam int RC = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fa  = 1'b0;
    logic       fb  = 1'b0;
    logic       oEnA, oEnB, oRstA_n, oWdRearmA, oFailAll;
    logic [7:0] oSwitchCnt;
    logic [2:0] oState;

    dsp_failover_ctrl #(
        .DEBOUNCE (DB),
        .GUARD    (GD),
        .RST_PULSE(RP),
        .RECOVER  (RC)
    ) dut (
        .iClk      (clk),
        .iRst      (rst),
        .iFaultA   (fa),
        .iFaultB   (fb),
        .oEnA      (oEnA),
        .oEnB      (oEnB),
        .oRstA_n   (oRstA_n),
        .oWdRearmA (oWdRearmA),
        .oFailAll  (oFailAll),
        .oSwitchCnt(oSwitchCnt),
        .oState    (oState)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int en_a;
        int en_b;
        int rst_n;
        int fail;
        int sw;
        int rearm;
        int at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   cyc        = 0;
    int   overlap    = 0;
    int   rearm_seen = 0;
    int   exp_rearm  = 0;
    int   exp_sw     = 0;
    int   prev_state = 0;
    bit   mon_en     = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: exclusive-enable watch, re-arm pulse count, transition scoreboard
    always @(negedge clk) begin
        if (oEnA === 1'b1 && oEnB === 1'b1) overlap++;
        if (mon_en && oWdRearmA === 1'b1) rearm_seen++;
        if (mon_en && int'(oState) != prev_state) begin
            $display("cyc %0d: state %0d -> %0d enA=%0b enB=%0b rstA_n=%0b rearm=%0b all=%0b sw=%0d",
                     cyc, prev_state, oState, oEnA, oEnB, oRstA_n, oWdRearmA, oFailAll, oSwitchCnt);
            if (sb.size() == 0) begin
                check_eq("unexpected_transition", oState, prev_state);
            end else begin
                mon_e = sb.pop_front();
                check_eq("state",    oState,     mon_e.st);
                check_eq("at_cycle", cyc,        mon_e.at);
                check_eq("en_a",     oEnA,       mon_e.en_a);
                check_eq("en_b",     oEnB,       mon_e.en_b);
                check_eq("rst_a_n",  oRstA_n,    mon_e.rst_n);
                check_eq("fail_all", oFailAll,   mon_e.fail);
                check_eq("sw_cnt",   oSwitchCnt, mon_e.sw);
                check_eq("rearm",    oWdRearmA,  mon_e.rearm);
            end
        end
        prev_state = int'(oState);
    end

    task automatic push(input state_e st, input int at, input bit bump);
        exp_t e;
        if (bump) exp_sw = (exp_sw == 255) ? 255 : exp_sw + 1;
        e.st    = int'(st);
        e.en_a  = (st == RUN_A) ? 1 : 0;
        e.en_b  = (st == RST_A || st == WAIT_A || st == RUN_B) ? 1 : 0;
        e.rst_n = (st == RST_A) ? 0 : 1;
        e.fail  = (st == FAIL_ALL) ? 1 : 0;
        e.rearm = (st == WAIT_A) ? 1 : 0;
        if (st == WAIT_A) exp_rearm++;
        e.sw    = exp_sw;
        e.at    = at;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag, input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge clk);
        check_eq(tag, sb.size(), 0);
    endtask

    task automatic raise_a(input int n, output int c);
        @(negedge clk);
        c  = cyc;
        fa = 1'b1;
        repeat (n) @(negedge clk);
        fa = 1'b0;
    endtask

    task automatic raise_b(input int n, output int c);
        @(negedge clk);
        c  = cyc;
        fb = 1'b1;
        repeat (n) @(negedge clk);
        fb = 1'b0;
    endtask

    // Debounced A fault, guard, A reset pulse, then entry into WAIT_A
    task automatic go_to_wait(output int t);
        int c;
        raise_a(DB, c);
        t = c + DB + 2;
        push(GUARD_AB, t, 1'b0);
        t += GD;
        push(RST_A, t, 1'b1);
        t += RP;
        push(WAIT_A, t, 1'b0);
    endtask

    // From WAIT_A back to RUN_A, via failback or via a B fault in RUN_B
    task automatic back_to_a(input int t0);
        int t;
        int c;
        t = t0 + RC;
`ifdef FAILOVER_FAILBACK_EN
        push(GUARD_BA, t, 1'b0);
        t += GD;
        push(RUN_A, t, 1'b1);
        drain("drain_failback", GD + RP + RC + GD + 4 * DB + 40);
`else
        push(RUN_B, t, 1'b0);
        drain("drain_run_b", GD + RP + RC + 2 * DB + 40);
        raise_b(DB, c);
        t = c + DB + 2;
        push(GUARD_BA, t, 1'b0);
        t += GD;
        push(RUN_A, t, 1'b1);
        drain("drain_b_fault", GD + 2 * DB + 40);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int c;
        int t;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_state",    oState,     RUN_A);
        check_eq("rst_en_a",     oEnA,       1);
        check_eq("rst_en_b",     oEnB,       0);
        check_eq("rst_rst_a_n",  oRstA_n,    1);
        check_eq("rst_rearm",    oWdRearmA,  0);
        check_eq("rst_fail_all", oFailAll,   0);
        check_eq("rst_sw_cnt",   oSwitchCnt, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // One cycle short of the debounce threshold: nothing happens
        raise_a(DB - 1, c);
        repeat (4 * DB) @(negedge clk);
        check_eq("glitch_state",  oState,     RUN_A);
        check_eq("glitch_en_a",   oEnA,       1);
        check_eq("glitch_sw_cnt", oSwitchCnt, 0);

        // Exactly DEBOUNCE high cycles: full failover and return to A
        go_to_wait(t);
        back_to_a(t);
        check_eq("trip_en_a",   oEnA,       1);
        check_eq("trip_sw_cnt", oSwitchCnt, 2);

        // B fault while waiting on A: both down until reset
        go_to_wait(t);
        drain("drain_wait", GD + RP + 2 * DB + 40);
        @(negedge clk);
        c  = cyc;
        fb = 1'b1;
        push(FAIL_ALL, c + DB + 2, 1'b0);
        drain("drain_fail_all", DB + 20);
        repeat (200) @(negedge clk);
        check_eq("hold_state",    oState,   FAIL_ALL);
        check_eq("hold_fail_all", oFailAll, 1);
        check_eq("hold_en_a",     oEnA,     0);
        check_eq("hold_en_b",     oEnB,     0);
        check_eq("hold_rst_a_n",  oRstA_n,  1);
        fb = 1'b0;
        @(negedge clk);
        c      = cyc;
        rst    = 1'b1;
        exp_sw = 0;
        push(RUN_A, c + 1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drain("drain_fail_rst", 5);

        // Reset in the middle of the A reset pulse
        raise_a(DB, c);
        t = c + DB + 2;
        push(GUARD_AB, t, 1'b0);
        t += GD;
        push(RST_A, t, 1'b1);
        drain("drain_rst_a", GD + 2 * DB + 40);
        repeat (5) @(negedge clk);
        c      = cyc;
        rst    = 1'b1;
        exp_sw = 0;
        push(RUN_A, c + 1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_state",   oState,     RUN_A);
        check_eq("midrst_rst_a_n", oRstA_n,    1);
        check_eq("midrst_en_a",    oEnA,       1);
        check_eq("midrst_sw_cnt",  oSwitchCnt, 0);
        drain("drain_midrst", 5);

        // 300 handovers: counter saturates
        for (int i = 0; i < 150; i++) begin
            go_to_wait(t);
            back_to_a(t);
        end
        check_eq("sw_saturate", oSwitchCnt, 255);

        check_eq("no_enable_overlap", overlap,    0);
        check_eq("rearm_pulses",      rearm_seen, exp_rearm);
        check_eq("scoreboard_empty",  sb.size(),  0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
